// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding and constants for the fetch stage
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode hand-off bundle
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] PC;
  logic [31:0] PC8;
  logic [31:0] IR;

  modport master (
    output imem_req_valid, imem_addr, out_valid, PC, PC8, IR,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, out_valid, PC, PC8, IR,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, single-outstanding imem fetch and IF/ID hand-off
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc8_q, pc8_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] npc;

  assign npc = align_word(bus.redirect_pc);

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.out_valid      = (state_q == S_HOLD);
  assign bus.PC             = pc_out_q;
  assign bus.PC8            = pc8_q;
  assign bus.IR             = ir_q;

  // Next state, PC mux and output bundle capture; redirect overrides everything else
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    pc_out_d = pc_out_q;
    pc8_d    = pc8_q;
    ir_d     = ir_q;
    case (state_q)
      S_REQ: begin
        if (bus.redirect) pc_d = npc;
        if (bus.imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = bus.redirect;
        end
      end
      S_WAIT: begin
        if (bus.redirect) pc_d = npc;
        if (bus.imem_rsp_valid) begin
          state_d = (drop_q || bus.redirect) ? S_REQ : S_HOLD;
          drop_d  = 1'b0;
          if (!drop_q && !bus.redirect) begin
            ir_d     = bus.imem_rsp_data;
            pc_out_d = pc_q;
            pc8_d    = pc_q + 2 * WORD_BYTES;
          end
        end else if (bus.redirect) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.redirect || bus.out_ready) begin
          state_d = S_REQ;
          pc_d    = bus.redirect ? npc : pc_q + WORD_BYTES;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      pc_out_q <= '0;
      pc8_q    <= '0;
      ir_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      pc_out_q <= pc_out_d;
      pc8_q    <= pc8_d;
      ir_q     <= ir_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven fetches plus redirect/reset/wrap sequences against a scoreboard
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          stall;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc8;
    logic [31:0] exp_ir;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tbl[4];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          fire_n = 0;
  int          acc_n = 0;
  int          fire_cyc = 0;
  int          lat = 1;
  int          cnt = 0;
  logic        acc = 1'b0;
  logic        fire = 1'b0;
  logic        pend = 1'b0;
  logic        seen_bad = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] mem_data = '0;
  logic [31:0] pdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // One clock: observe the coming edge, then play the memory for the next cycle
  task automatic cyc();
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    fire = bus.out_valid && bus.out_ready;
    if (acc) begin
      acc_addr = bus.imem_addr;
      acc_n++;
    end
    if (bus.IR === 32'hDEADBEEF) seen_bad = 1'b1;
    if (fire) begin
      fire_n++;
      fire_cyc = cyc_n;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: PC %h IR %h with empty scoreboard", bus.PC, bus.IR);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("PC", bus.PC, e.pc);
        chk("PC8", bus.PC8, e.pc8);
        chk("IR", bus.IR, e.ir);
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    bus.redirect = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      cnt   = lat;
      pdata = mem_data;
    end
    if (pend) begin
      if (cnt <= 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = pdata;
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_acc();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!acc && k < 50);
    if (!acc) timeout("wait_acc");
  endtask

  task automatic wait_fire();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!fire && k < 50);
    if (!fire) timeout("wait_fire");
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      cyc();
      k++;
    end
    if (!bus.out_valid) timeout("wait_valid");
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pc8, input logic [31:0] ir);
    exp_t e;
    e.pc  = pc;
    e.pc8 = pc8;
    e.ir  = ir;
    sb_q.push_back(e);
  endtask

  initial begin
    int   f0;
    int   prev_fire;
    logic bad;
    tbl[0] = '{32'h0000_0013, 0,  32'h3000, 32'h3000, 32'h3008, 32'h0000_0013};
    tbl[1] = '{32'h0040_0093, 0,  32'h3004, 32'h3004, 32'h300C, 32'h0040_0093};
    tbl[2] = '{32'h0080_0113, 0,  32'h3008, 32'h3008, 32'h3010, 32'h0080_0113};
    tbl[3] = '{32'h00C0_0193, 10, 32'h300C, 32'h300C, 32'h3014, 32'h00C0_0193};
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_PC", bus.PC, 0);
    chk("rst_PC8", bus.PC8, 0);
    chk("rst_IR", bus.IR, 0);
    chk("rst_addr", bus.imem_addr, 32'h3000);
    reset = 1'b1;
    bus.imem_req_ready = 1'b1;
    prev_fire = 0;
    for (int i = 0; i < 4; i++) begin
      mem_data = tbl[i].data;
      bus.out_ready = (tbl[i].stall == 0);
      push(tbl[i].exp_pc, tbl[i].exp_pc8, tbl[i].exp_ir);
      wait_acc();
      chk("tbl_addr", acc_addr, tbl[i].exp_addr);
      if (tbl[i].stall > 0) begin
        wait_valid();
        f0  = acc_n;
        bad = 1'b0;
        repeat (tbl[i].stall) begin
          cyc();
          if (bus.PC !== tbl[i].exp_pc || bus.IR !== tbl[i].exp_ir || bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b1) bad = 1'b1;
        end
        chk("stall_stable", bad, 0);
        chk("stall_no_req", acc_n - f0, 0);
        bus.out_ready = 1'b1;
      end
      wait_fire();
      if (i > 0 && tbl[i].stall == 0 && tbl[i-1].stall == 0) chk("period", fire_cyc - prev_fire, 3);
      prev_fire = fire_cyc;
    end
    // Redirect while waiting on a slow response that must be dropped
    lat = 4;
    mem_data = 32'hDEADBEEF;
    f0 = acc_n;
    wait_acc();
    chk("post_stall_one_req", acc_n - f0, 1);
    chk("s3_addr", acc_addr, 32'h3010);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3403;
    cyc();
    chk("s3_pc_q", bus.imem_addr, 32'h3400);
    mem_data = 32'h1111_1111;
    lat = 1;
    push(32'h3400, 32'h3408, 32'h1111_1111);
    f0 = fire_n;
    wait_acc();
    chk("s3_new_addr", acc_addr, 32'h3400);
    chk("s3_no_out", fire_n - f0, 0);
    wait_fire();
    // Redirect with ready low, then redirect coinciding with acceptance
    bus.imem_req_ready = 1'b0;
    chk("s4_addr_pre", bus.imem_addr, 32'h3404);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3010;
    cyc();
    chk("s4_withdraw_addr", bus.imem_addr, 32'h3010);
    chk("s4_withdraw_valid", bus.imem_req_valid, 1);
    bus.imem_req_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3803;
    lat = 2;
    mem_data = 32'h3333_3333;
    f0 = fire_n;
    cyc();
    chk("s4_acc", acc, 1);
    chk("s4_acc_addr", acc_addr, 32'h3010);
    mem_data = 32'h4444_4444;
    lat = 1;
    push(32'h3800, 32'h3808, 32'h4444_4444);
    wait_acc();
    chk("s4_new_addr", acc_addr, 32'h3800);
    chk("s4_no_out", fire_n - f0, 0);
    wait_fire();
    // Redirect together with out_ready in HOLD consumes the held instruction once
    bus.imem_req_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3020;
    cyc();
    bus.imem_req_ready = 1'b1;
    mem_data = 32'h5555_5555;
    push(32'h3020, 32'h3028, 32'h5555_5555);
    bus.out_ready = 1'b0;
    wait_acc();
    chk("s5_addr", acc_addr, 32'h3020);
    wait_valid();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3100;
    bus.out_ready = 1'b1;
    cyc();
    chk("s5_fire", fire, 1);
    chk("s5_out_valid", bus.out_valid, 0);
    chk("s5_next_addr", bus.imem_addr, 32'h3100);
    mem_data = 32'h6666_6666;
    push(32'h3100, 32'h3108, 32'h6666_6666);
    wait_acc();
    chk("s5_acc_addr", acc_addr, 32'h3100);
    wait_fire();
    // Asynchronous reset while a response is outstanding
    lat = 4;
    mem_data = 32'h7777_7777;
    wait_acc();
    bus.imem_req_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_PC", bus.PC, 0);
    chk("arst_PC8", bus.PC8, 0);
    chk("arst_IR", bus.IR, 0);
    chk("arst_addr", bus.imem_addr, 32'h3000);
    cyc();
    cyc();
    reset = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      cyc();
      if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1) bad = 1'b1;
    end
    chk("arst_late_rsp_ignored", bad, 0);
    lat = 1;
    bus.imem_req_ready = 1'b1;
    mem_data = 32'h8888_8888;
    push(32'h3000, 32'h3008, 32'h8888_8888);
    wait_acc();
    chk("arst_new_addr", acc_addr, 32'h3000);
    wait_fire();
    // PC wrap at the top of the address space
    bus.imem_req_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.imem_req_ready = 1'b1;
    mem_data = 32'h9999_9999;
    push(32'hFFFF_FFFC, 32'h0000_0004, 32'h9999_9999);
    wait_acc();
    chk("wrap_addr0", acc_addr, 32'hFFFF_FFFC);
    wait_fire();
    mem_data = 32'hAAAA_AAAA;
    push(32'h0000_0000, 32'h0000_0008, 32'hAAAA_AAAA);
    wait_acc();
    chk("wrap_addr1", acc_addr, 32'h0000_0000);
    wait_fire();
    chk("sb_empty", 32'(sb_q.size()), 0);
    chk("deadbeef_never_on_IR", seen_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
